scu_hazard_ctrl: RTL and testbench

- Parametrised hazard, forwarding and flush controller for the SCU pipelined core, sitting beside the IF/ID, ID/EX and EX/WB buffers.
- Adds what the current datapath lacks: operand forwarding, load-use stalls, a wrong-path flush after a taken branch or jump, and a freeze while the data memory is busy.
- Generalised in post-decode pipeline depth, flush depth and data width; exports stall and flush counters.

---
 rtl/scu_pipe_pkg.sv | 23 ++
 rtl/scu_hazard_scoreboard.sv | 52 +++++
 rtl/scu_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_scu_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/scu_pipe_pkg.sv
// Shared types and constants for the SCU pipeline hazard/forwarding controller.
package scu_pipe_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EX = 2'd1;
    localparam logic [1:0] FWD_WB = 2'd2;

    // Scoreboard rd field is sized for the widest supported register file (REG_AW <= 8).
    localparam int SB_RD_W = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               reg_write;
        logic               is_load;
    } sb_entry_t;

endpackage

// File: rtl/scu_hazard_scoreboard.sv
// Destination scoreboard for the stages from EX up to (not including) WB,
// plus per-stage source match vectors for rs and rt.
module scu_hazard_scoreboard
    import scu_pipe_pkg::*;
#(
    parameter int REG_AW = 6,
    parameter int N      = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              push_valid,
    input  logic [REG_AW-1:0] push_rd,
    input  logic              push_reg_write,
    input  logic              push_load,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              rs_used,
    input  logic              rt_used,
    output logic [N-1:0]      rs_match,
    output logic [N-1:0]      rt_match,
    output logic              ex_is_load
);

    sb_entry_t [N-1:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (!hold) begin
            for (int k = N - 1; k > 0; k--) sb_d[k] = sb_q[k-1];
            sb_d[0].valid     = push_valid;
            sb_d[0].rd        = SB_RD_W'(push_rd);
            sb_d[0].reg_write = push_reg_write;
            sb_d[0].is_load   = push_load;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) sb_q <= '0;
        else       sb_q <= sb_d;
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            rs_match[k] = rs_used & sb_q[k].valid & sb_q[k].reg_write & (sb_q[k].rd == SB_RD_W'(rs));
            rt_match[k] = rt_used & sb_q[k].valid & sb_q[k].reg_write & (sb_q[k].rd == SB_RD_W'(rt));
        end
    end

    assign ex_is_load = sb_q[0].is_load;

endmodule

// File: rtl/scu_hazard_ctrl.sv
// Hazard, forwarding and wrong-path flush controller for the SCU pipeline:
// operand bypass, load-use / intermediate-stage stalls, memory freeze, perf counters.
module scu_hazard_ctrl
    import scu_pipe_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 6,
    parameter int PIPE_DEPTH   = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              redirect,
    input  logic              mem_busy,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              bubble_ex,
    output logic              flush_id,
    output logic [DATA_W-1:0] fwd_rs_data,
    output logic [DATA_W-1:0] fwd_rt_data,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int SB_N = PIPE_DEPTH - 1;
    localparam int FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    logic [SB_N-1:0] rs_m, rt_m;
    logic            ex_load, wb_rs, wb_rt, load_use, mid_stall, hazard, push;
    flush_state_e    state_q;
    logic [FC_W-1:0] fcnt_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    scu_hazard_scoreboard #(.REG_AW(REG_AW), .N(SB_N)) u_sb (
        .clock          (clock),
        .reset          (reset),
        .hold           (mem_busy),
        .push_valid     (push),
        .push_rd        (id_rd),
        .push_reg_write (id_reg_write),
        .push_load      (id_mem_read),
        .rs             (id_rs),
        .rt             (id_rt),
        .rs_used        (id_rs_used),
        .rt_used        (id_rt_used),
        .rs_match       (rs_m),
        .rt_match       (rt_m),
        .ex_is_load     (ex_load)
    );

    assign wb_rs     = id_rs_used & wb_reg_write & (wb_rd == id_rs);
    assign wb_rt     = id_rt_used & wb_reg_write & (wb_rd == id_rt);
    assign load_use  = ex_load & (rs_m[0] | rt_m[0]);
    // Stall when the nearest matching writer sits beyond EX: its value is not on any bypass.
    assign mid_stall = ((|rs_m) & ~rs_m[0]) | ((|rt_m) & ~rt_m[0]);
    assign hazard    = load_use | mid_stall;
    assign push      = id_valid & ~stall_id & ~flush_id & ~bubble_ex;

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (reset) begin
            stall_if = 1'b0;
        end else if (mem_busy) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
        end else if (redirect || state_q == ST_FLUSH) begin
            flush_id  = 1'b1;
            bubble_ex = redirect;
        end else if (hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    always_comb begin
        fwd_rs_sel  = FWD_RF;
        fwd_rs_data = id_rs_data;
        fwd_rt_sel  = FWD_RF;
        fwd_rt_data = id_rt_data;
        if (rs_m[0] && !ex_load) begin
            fwd_rs_sel  = FWD_EX;
            fwd_rs_data = ex_result;
        end else if (wb_rs) begin
            fwd_rs_sel  = FWD_WB;
            fwd_rs_data = wb_data;
        end
        if (rt_m[0] && !ex_load) begin
            fwd_rt_sel  = FWD_EX;
            fwd_rt_data = ex_result;
        end else if (wb_rt) begin
            fwd_rt_sel  = FWD_WB;
            fwd_rt_data = wb_data;
        end
        if (reset) begin
            fwd_rs_sel  = FWD_RF;
            fwd_rs_data = '0;
            fwd_rt_sel  = FWD_RF;
            fwd_rt_data = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else if (!mem_busy) begin
            case (state_q)
                ST_RUN: if (redirect && FLUSH_CYCLES > 1) begin
                    state_q <= ST_FLUSH;
                    fcnt_q  <= FC_RELOAD;
                end
                ST_FLUSH: begin
                    if (redirect)           fcnt_q  <= FC_RELOAD;
                    else if (fcnt_q == '0)  state_q <= ST_RUN;
                    else                    fcnt_q  <= fcnt_q - 1'b1;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // stall_id is also raised by the memory freeze, which must not count.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!mem_busy) begin
            if (stall_id && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_id && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_scu_hazard_ctrl.sv
// Directed bench for scu_hazard_ctrl with a 3-deep post-decode pipe and 2-slot flush.
module tb_scu_hazard_ctrl;

    localparam int DATA_W = 32;
    localparam int REG_AW = 6;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd, wb_rd;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, ex_result, wb_data;
    logic              wb_reg_write, redirect, mem_busy;
    logic              stall_if, stall_id, stall_ex, bubble_ex, flush_id;
    logic [DATA_W-1:0] fwd_rs_data, fwd_rt_data;
    logic [1:0]        fwd_rs_sel, fwd_rt_sel;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    scu_hazard_ctrl #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .PIPE_DEPTH(3), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_result(ex_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .redirect(redirect), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .flush_id(flush_id),
        .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs_used = 0; id_rt_used = 0; id_reg_write = 0; id_mem_read = 0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        wb_rd = '0; wb_reg_write = 0; wb_data = '0;
        redirect = 0; mem_busy = 0;
    endtask

    // ID issues an instruction writing rd (load if ld)
    task automatic issue(input logic [REG_AW-1:0] rd, input logic ld);
        idle();
        id_valid = 1; id_rd = rd; id_reg_write = 1; id_mem_read = ld;
    endtask

    task automatic ctl(input string tag, input logic [4:0] exp);
        chk(tag, {stall_if, stall_id, stall_ex, bubble_ex, flush_id}, exp);
    endtask

    initial begin
        idle();
        id_rs_data = 32'hAAAA_0001; id_rt_data = 32'hBBBB_0002; ex_result = 32'h1234;
        reset = 1;
        redirect = 1; id_valid = 1; id_rs_used = 1;
        tick(); tick();
        ctl("rst_ctl", 5'b00000);
        chk("rst_rssel", fwd_rs_sel, 0);
        reset = 0; idle(); #1;
        chk("rst_scnt", stall_cnt, 0);
        chk("rst_fcnt", flush_cnt, 0);
        ctl("rst_idle", 5'b00000);

        // EX forwarding, then intermediate-stage stall, then WB forwarding
        issue(5, 0); #1;
        ctl("alu_issue", 5'b00000);
        tick();
        idle(); id_valid = 1; id_rs = 5; id_rs_used = 1; #1;
        chk("ex_sel", fwd_rs_sel, 1);
        chk("ex_data", fwd_rs_data, 32'h1234);
        ctl("ex_nostall", 5'b00000);
        tick();
        #1;
        ctl("mid_stall", 5'b11010);
        chk("mid_sel", fwd_rs_sel, 0);
        tick();
        id_rt = 9; id_rt_used = 1;
        wb_rd = 5; wb_reg_write = 1; wb_data = 32'h5555; #1;
        chk("wb_sel", fwd_rs_sel, 2);
        chk("wb_data", fwd_rs_data, 32'h5555);
        chk("rf_rtsel", fwd_rt_sel, 0);
        chk("rf_rtdata", fwd_rt_data, 32'hBBBB_0002);
        ctl("wb_nostall", 5'b00000);
        chk("scnt1", stall_cnt, 1);
        tick();

        // Load-use on rt, frozen by mem_busy, then resumes
        issue(7, 1); #1;
        tick();
        idle(); id_valid = 1; id_rt = 7; id_rt_used = 1; #1;
        ctl("lu_stall", 5'b11010);
        mem_busy = 1; #1;
        ctl("busy_ctl", 5'b11100);
        tick();
        redirect = 1; #1;
        ctl("busy_redir", 5'b11100);
        tick();
        redirect = 0;
        tick();
        mem_busy = 0; #1;
        ctl("lu_resume", 5'b11010);
        chk("scnt_frozen", stall_cnt, 1);
        chk("fcnt_frozen", flush_cnt, 0);
        tick();
        #1;
        ctl("lu_mid", 5'b11010);
        tick();
        wb_rd = 7; wb_reg_write = 1; wb_data = 32'hBEEF; #1;
        chk("lu_wbsel", fwd_rt_sel, 2);
        chk("lu_wbdata", fwd_rt_data, 32'hBEEF);
        ctl("lu_done", 5'b00000);
        chk("scnt3", stall_cnt, 3);
        tick();

        // Redirect beats a load-use stall, flush lasts two cycles
        issue(3, 1); #1;
        tick();
        idle(); id_valid = 1; id_rs = 3; id_rs_used = 1; redirect = 1; #1;
        ctl("redir_lu", 5'b00011);
        tick();
        idle(); #1;
        ctl("flush2", 5'b00001);
        tick();
        ctl("flush_end", 5'b00000);
        chk("fcnt2", flush_cnt, 2);

        // Redirect in FLUSH restarts the window
        redirect = 1; tick();
        #1; ctl("rf_a", 5'b00011);
        tick(); redirect = 0; #1;
        ctl("rf_b", 5'b00001);
        tick();
        ctl("rf_end", 5'b00000);
        chk("fcnt5", flush_cnt, 5);

        // Flush counter saturates
        redirect = 1;
        for (int i = 0; i < 20; i++) tick();
        redirect = 0;
        chk("fcnt_sat", flush_cnt, 15);
        tick(); tick();

        // Reset in the middle of a FLUSH
        issue(4, 0); #1;
        tick();
        idle(); redirect = 1; tick();
        redirect = 0; reset = 1; #1;
        ctl("rst_mid_ctl", 5'b00000);
        tick();
        reset = 0; id_valid = 1; id_rs = 4; id_rs_used = 1; #1;
        ctl("post_rst_ctl", 5'b00000);
        chk("post_rst_sel", fwd_rs_sel, 0);
        chk("post_rst_scnt", stall_cnt, 0);
        chk("post_rst_fcnt", flush_cnt, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
